// File: rtl/acct_shadow_bank_if.sv
// Register bus carrying one 32-bit access per valid/ready handshake.
// The slave side (modport in) answers with combinational rdata/error/ready.
interface REG_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;
    logic                  ready;

    modport in  (input addr, write, wdata, valid, output rdata, error, ready);
    modport out (output addr, write, wdata, valid, input rdata, error, ready);
endinterface

// File: rtl/acct_shadow_bank.sv
// Shadow/active access-control register bank with an atomic per-slave commit FSM.
// Optional macro ACCT_VIOL_CNT_EN adds the saturating violation counter, sticky flag and irq.
module acct_shadow_bank #(
    parameter int unsigned NB_SLAVE        = 3,
    parameter int unsigned WORDS_PER_SLAVE = 3,
    parameter logic [31:0] RESET_VAL       = 32'hFFFF_FFFF,
    parameter int unsigned VIOL_CNT_W      = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [2*NB_SLAVE-1:0]                         reglk_ctrl_i,
    output logic [NB_SLAVE-1:0][32*WORDS_PER_SLAVE-1:0]   acc_ctrl_o,
    output logic                                          commit_done_o,
    output logic                                          viol_irq_o,
    REG_BUS.in                                            external_bus_io
);
    localparam int unsigned PTR_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
    localparam int unsigned ACT_BASE = 64;
    localparam int unsigned CTRL_IDX = 128;
    localparam int unsigned STAT_IDX = 129;

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_e;

    state_e                                     state_q, state_d;
    logic [PTR_W-1:0]                           ptr_q, ptr_d;
    logic [NB_SLAVE-1:0][32*WORDS_PER_SLAVE-1:0] shadow_q, shadow_d;
    logic [NB_SLAVE-1:0][32*WORDS_PER_SLAVE-1:0] active_q, active_d;

    logic [NB_SLAVE-1:0][WORDS_PER_SLAVE-1:0]   sel_sh, sel_ac;
    logic [7:0]                                 idx;
    logic                                       is_ctrl, is_stat;
    logic                                       wr, ctrl_wr, viol;
    logic [31:0]                                rdata, status;
    logic [VIOL_CNT_W-1:0]                      viol_cnt;
    logic                                       viol_flag;
    logic                                       unused_addr;

    assign idx         = external_bus_io.addr[9:2];
    assign unused_addr = ^{external_bus_io.addr[31:10], external_bus_io.addr[1:0]};
    assign is_ctrl     = (int'(idx) == CTRL_IDX);
    assign is_stat     = (int'(idx) == STAT_IDX);

    always_comb begin
        sel_sh = '0;
        sel_ac = '0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            for (int k = 0; k < WORDS_PER_SLAVE; k++) begin
                sel_sh[i][k] = (int'(idx) == i*WORDS_PER_SLAVE + k);
                sel_ac[i][k] = (int'(idx) == ACT_BASE + i*WORDS_PER_SLAVE + k);
            end
        end
    end

    // Bus is stalled for the whole COPY phase so the shadow cannot change mid-commit.
    assign external_bus_io.ready = (state_q != COPY);
    assign wr      = external_bus_io.valid & external_bus_io.ready & external_bus_io.write;
    assign ctrl_wr = wr & is_ctrl;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        shadow_d = shadow_q;
        active_d = active_q;
        viol     = 1'b0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            if (wr && (|sel_sh[i])) begin
                if (reglk_ctrl_i[2*i+1]) begin
                    viol = 1'b1;
                end else begin
                    for (int k = 0; k < WORDS_PER_SLAVE; k++) begin
                        if (sel_sh[i][k]) shadow_d[i][32*k +: 32] = external_bus_io.wdata;
                    end
                end
            end
        end
        case (state_q)
            IDLE: begin
                if (ctrl_wr && external_bus_io.wdata[0]) begin
                    ptr_d   = '0;
                    state_d = COPY;
                end
            end
            COPY: begin
                // Lock is sampled per slave, so a lock raised mid-commit hits later slaves only.
                for (int i = 0; i < NB_SLAVE; i++) begin
                    if (ptr_q == PTR_W'(i) && !reglk_ctrl_i[2*i+1]) active_d[i] = shadow_q[i];
                end
                ptr_d = ptr_q + PTR_W'(1);
                if (ptr_q == PTR_W'(NB_SLAVE-1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            shadow_q <= {(NB_SLAVE*WORDS_PER_SLAVE){RESET_VAL}};
            active_q <= {(NB_SLAVE*WORDS_PER_SLAVE){RESET_VAL}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

`ifdef ACCT_VIOL_CNT_EN
    logic [VIOL_CNT_W-1:0] cnt_q, cnt_d;
    logic                  flag_q, flag_d;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (ctrl_wr && external_bus_io.wdata[1]) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (viol) begin
            flag_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + VIOL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign viol_cnt  = cnt_q;
    assign viol_flag = flag_q;
`else
    logic unused_viol;
    assign unused_viol = viol;
    assign viol_cnt    = '0;
    assign viol_flag   = 1'b0;
`endif

    always_comb begin
        status                       = '0;
        status[0]                    = (state_q != IDLE);
        status[1]                    = viol_flag;
        status[16 +: VIOL_CNT_W]     = viol_cnt;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            for (int k = 0; k < WORDS_PER_SLAVE; k++) begin
                if (sel_sh[i][k] && !reglk_ctrl_i[2*i]) rdata = shadow_q[i][32*k +: 32];
                if (sel_ac[i][k] && !reglk_ctrl_i[2*i]) rdata = active_q[i][32*k +: 32];
            end
        end
        if (is_stat) rdata = status;
    end

    assign external_bus_io.rdata = rdata;
    assign external_bus_io.error = ~((|sel_sh) | (|sel_ac) | is_ctrl | is_stat);
    assign acc_ctrl_o            = active_q;
    assign commit_done_o         = (state_q == DONE);
    assign viol_irq_o            = viol_flag;
endmodule

// File: tb/tb_acct_shadow_bank.sv
// Directed bench for acct_shadow_bank: commit timing, locks, violations, address map, reset abort.
module tb_acct_shadow_bank;
    localparam int NB  = 3;
    localparam int WPS = 3;
`ifdef ACCT_VIOL_CNT_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [2*NB-1:0]           reglk;
    logic [NB-1:0][32*WPS-1:0] acc;
    logic                      done, irq;
    int                        total = 0;
    int                        bad   = 0;
    logic [31:0]               rd;
    logic                      er;
    int                        lowcnt, donecnt;

    REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    acct_shadow_bank #(.NB_SLAVE(NB), .WORDS_PER_SLAVE(WPS)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .reglk_ctrl_i    (reglk),
        .acc_ctrl_o      (acc),
        .commit_done_o   (done),
        .viol_irq_o      (irq),
        .external_bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_act_reset(input string tag);
        for (int i = 0; i < NB; i++)
            for (int k = 0; k < WPS; k++)
                chk($sformatf("%s[%0d][%0d]", tag, i, k), acc[i][32*k +: 32], 32'hFFFF_FFFF);
    endtask

    task automatic bus_wr(input int idx, input logic [31:0] data);
        @(negedge clk);
        bus.addr  = 32'(idx) << 2;
        bus.wdata = data;
        bus.write = 1'b1;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic bus_rd(input int idx, output logic [31:0] data, output logic err);
        @(negedge clk);
        bus.addr  = 32'(idx) << 2;
        bus.write = 1'b0;
        bus.valid = 1'b1;
        #1;
        data      = bus.rdata;
        err       = bus.error;
        bus.valid = 1'b0;
    endtask

    // Bounded observation window: counts stalled cycles and done pulses.
    task automatic watch(input int cycles, output int lo, output int dn);
        lo = 0;
        dn = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!bus.ready) lo++;
            if (done) dn++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        reglk     = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.write = 1'b0;
        bus.valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk_act_reset("rst_act");
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_ready", {31'b0, bus.ready}, 32'd1);
        bus_rd(129, rd, er);
        chk("rst_status", rd, 32'h0);

        // Shadow write then commit
        bus_wr(4, 32'h1234_5678);
        chk("pre_commit_act", acc[1][63:32], 32'hFFFF_FFFF);
        bus_rd(4, rd, er);
        chk("shadow_rd4", rd, 32'h1234_5678);
        bus_wr(128, 32'h1);
        watch(10, lowcnt, donecnt);
        chk("commit_stall", 32'(lowcnt), 32'd3);
        chk("commit_pulse", 32'(donecnt), 32'd1);
        chk("act_1_1", acc[1][63:32], 32'h1234_5678);
        chk("act_0_0", acc[0][31:0], 32'hFFFF_FFFF);
        bus_rd(68, rd, er);
        chk("active_rd68", rd, 32'h1234_5678);
        chk("active_rd68_err", {31'b0, er}, 32'd0);

        // Write lock on slave 1
        reglk = 6'b001000;
        bus_wr(3, 32'h0);
        bus_rd(3, rd, er);
        chk("locked_shadow", rd, 32'hFFFF_FFFF);
        chk("locked_wr_irq", {31'b0, irq}, {31'b0, VEN});
        bus_wr(128, 32'h1);
        watch(10, lowcnt, donecnt);
        chk("lk_commit_pulse", 32'(donecnt), 32'd1);
        chk("lk_act_1_0", acc[1][31:0], 32'hFFFF_FFFF);
        chk("lk_act_1_1", acc[1][63:32], 32'h1234_5678);
        bus_wr(64, 32'h0);
        chk("ro_active_wr", acc[0][31:0], 32'hFFFF_FFFF);
        bus_rd(129, rd, er);
        chk("status_1viol", rd, VEN ? 32'h0001_0002 : 32'h0);

`ifdef ACCT_VIOL_CNT_EN
        // Saturation: one long locked write burst
        @(negedge clk);
        bus.addr  = 32'(3) << 2;
        bus.wdata = 32'h0;
        bus.write = 1'b1;
        bus.valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.write = 1'b0;
        bus_rd(129, rd, er);
        chk("status_sat", rd, 32'hFFFF_0002);
`endif
        bus_wr(128, 32'h2);
        bus_rd(129, rd, er);
        chk("status_clr", rd, 32'h0);
        chk("irq_clr", {31'b0, irq}, 32'd0);

        // Clear together with commit start
        bus_wr(3, 32'h0);
        bus_wr(128, 32'h3);
        bus_rd(129, rd, er);
        chk("status_clr_commit", rd, 32'h1);
        watch(10, lowcnt, donecnt);
        chk("clr_commit_pulse", 32'(donecnt), 32'd1);
        chk("clr_commit_irq", {31'b0, irq}, 32'd0);

        // Read lock on slave 0 and address map holes
        reglk = 6'b000001;
        bus_rd(0, rd, er);
        chk("rdlock_sh0", rd, 32'h0);
        bus_rd(1, rd, er);
        chk("rdlock_sh1", rd, 32'h0);
        bus_rd(64, rd, er);
        chk("rdlock_act64", rd, 32'h0);
        bus_rd(3, rd, er);
        chk("unlocked_sh3", rd, 32'hFFFF_FFFF);
        bus_rd(130, rd, er);
        chk("hole130_rd", rd, 32'h0);
        chk("hole130_err", {31'b0, er}, 32'd1);
        bus_rd(9, rd, er);
        chk("hole9_err", {31'b0, er}, 32'd1);
        bus_rd(128, rd, er);
        chk("ctrl_rd", rd, 32'h0);
        chk("ctrl_err", {31'b0, er}, 32'd0);

        // Reset during the second COPY cycle
        reglk = '0;
        bus_wr(0, 32'hA5A5_A5A5);
        bus_wr(128, 32'h1);
        @(negedge clk);
        chk("abort_ready0", {31'b0, bus.ready}, 32'd0);
        @(negedge clk);
        chk("abort_copied0", acc[0][31:0], 32'hA5A5_A5A5);
        rst_n   = 1'b0;
        donecnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) donecnt++;
            if (c == 1) rst_n = 1'b1;
        end
        chk("abort_no_pulse", 32'(donecnt), 32'd0);
        chk_act_reset("abort_act");
        chk("abort_ready", {31'b0, bus.ready}, 32'd1);
        bus_rd(0, rd, er);
        chk("abort_shadow0", rd, 32'hFFFF_FFFF);
        bus_rd(129, rd, er);
        chk("abort_status", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
